// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one
// shared memory port, drives datapath strobes, counts retirements, traps on faults.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  fault_code
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [16:0] TIMEOUT_LIM = 17'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] retired_q, retired_d;
  logic        halted_q, halted_d;
  logic [1:0]  fault_q, fault_d;

  logic        req_s;
  logic        legal_s;
  logic        timeout_s;

  // A request is outstanding in FETCH and MEM; timeout fires when this wait cycle would hit the limit.
  always_comb begin
    req_s     = (state_q == S_FETCH) || (state_q == S_MEM);
    timeout_s = req_s && !mem_ready && (({1'b0, wait_q} + 17'd1) == TIMEOUT_LIM);
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_s = 1'b1;
      default:                           legal_s = 1'b0;
    endcase
  end

  // State, wait counter, retirement counter and fault registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 16'd0;
      retired_q <= 32'd0;
      halted_q  <= 1'b0;
      fault_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic plus counter and fault updates.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_TRAP;
          fault_d = 2'd2;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (legal_s) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          fault_d = 2'd1;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_R, OP_I, OP_LUI, OP_AUIPC: state_d = S_WB;
          OP_LOAD, OP_STORE:            state_d = S_MEM;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout_s) begin
          state_d = S_TRAP;
          fault_d = 2'd2;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    wait_d    = (req_s && !mem_ready) ? (wait_q + 16'd1) : 16'd0;
    // Only a transition into FETCH retires; wait cycles spent in FETCH do not.
    retired_d = ((state_d == S_FETCH) && (state_q != S_FETCH)) ? (retired_q + 32'd1) : retired_q;
    halted_d  = (state_d == S_TRAP);
  end

  // Datapath strobes, decoded from state, opcode and handshake; all held low during reset.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    reg_we       = 1'b0;
    wb_sel       = 2'd0;
    alu_src_a    = 2'd0;
    alu_src_b    = 1'b0;
    alu_op       = 2'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          pc_we   = mem_ready;
        end
        S_EXEC: begin
          case (opcode)
            OP_R: begin
              alu_op = 2'd2;
            end
            OP_I: begin
              alu_src_b = 1'b1;
              alu_op    = 2'd3;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_b = 1'b1;
            end
            OP_LUI: begin
              alu_src_a = 2'd2;
              alu_src_b = 1'b1;
            end
            OP_AUIPC: begin
              alu_src_a = 2'd1;
              alu_src_b = 1'b1;
            end
            OP_BR: begin
              alu_op = 2'd1;
              pc_we  = branch_cond;
              pc_src = branch_cond ? 2'd1 : 2'd0;
            end
            OP_JAL: begin
              reg_we = 1'b1;
              wb_sel = 2'd2;
              pc_we  = 1'b1;
              pc_src = 2'd1;
            end
            OP_JALR: begin
              alu_src_b = 1'b1;
              reg_we    = 1'b1;
              wb_sel    = 2'd2;
              pc_we     = 1'b1;
              pc_src    = 2'd2;
            end
            default: begin
              alu_op = 2'd0;
            end
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OP_STORE);
        end
        S_WB: begin
          reg_we = 1'b1;
          wb_sel = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end else begin
      mem_req = 1'b0;
    end
  end

  assign retired    = retired_q;
  assign halted     = halted_q;
  assign fault_code = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected strobe vectors are
// queued with their stimulus and compared on the falling edge as the DUT steps.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic        branch_cond = 1'b0;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, alu_src_b, halted;
  logic [1:0]  pc_src, wb_sel, alu_src_a, alu_op, fault_code;
  logic [31:0] retired;

  typedef struct {
    string       tag;
    logic        rdy;
    logic        bc;
    logic [17:0] exp;
  } item_t;

  item_t       sb_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [17:0] got_vec;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_cond(branch_cond),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .retired(retired), .halted(halted), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  assign got_vec = {fault_code, halted, mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
                    pc_src, reg_we, wb_sel, alu_src_a, alu_src_b, alu_op};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] v(input logic [1:0] fc, input logic h, input logic mreq,
                                    input logic mwe, input logic masel, input logic irwe,
                                    input logic pcwe, input logic [1:0] pcsrc,
                                    input logic regwe, input logic [1:0] wbsel,
                                    input logic [1:0] sa, input logic sb, input logic [1:0] op);
    return {fc, h, mreq, mwe, masel, irwe, pcwe, pcsrc, regwe, wbsel, sa, sb, op};
  endfunction

  task automatic push(input string tag, input logic rdy, input logic bc, input logic [17:0] exp);
    item_t it;
    it.tag = tag;
    it.rdy = rdy;
    it.bc  = bc;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  // Entered just after a rising edge; each item is one clock cycle.
  task automatic run_queue();
    item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      mem_ready   = it.rdy;
      branch_cond = it.bc;
      @(negedge clk);
      check_val(it.tag, {14'd0, got_vec}, {14'd0, it.exp});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check_val("rst_strobes", {17'd0, got_vec[14:0]}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_retired = 32'd0;
    check_val("rst_retired", retired, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_fault", {30'd0, fault_code}, 32'd0);
  endtask

  task automatic push_fetch(input int fw, input logic bc);
    for (int i = 0; i < fw; i++) push("fetch_wait", 1'b0, bc, v(0,0,1,0,0,0,0,0,0,0,0,0,0));
    push("fetch", 1'b1, bc, v(0,0,1,0,0,1,1,0,0,0,0,0,0));
    push("decode", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,0,0,0));
  endtask

  task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input logic bc);
    logic legal;
    legal  = 1'b1;
    opcode = op;
    push_fetch(fw, bc);
    case (op)
      OP_R: begin
        push("exec_r", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,0,0,2));
        push("wb_r", 1'b1, bc, v(0,0,0,0,0,0,0,0,1,0,0,0,0));
      end
      OP_I: begin
        push("exec_i", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,0,1,3));
        push("wb_i", 1'b1, bc, v(0,0,0,0,0,0,0,0,1,0,0,0,0));
      end
      OP_LUI: begin
        push("exec_lui", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,2,1,0));
        push("wb_lui", 1'b1, bc, v(0,0,0,0,0,0,0,0,1,0,0,0,0));
      end
      OP_AUIPC: begin
        push("exec_auipc", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,1,1,0));
        push("wb_auipc", 1'b1, bc, v(0,0,0,0,0,0,0,0,1,0,0,0,0));
      end
      OP_LOAD: begin
        push("exec_lw", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,0,1,0));
        for (int i = 0; i < mw; i++) push("mem_lw_wait", 1'b0, bc, v(0,0,1,0,1,0,0,0,0,0,0,0,0));
        push("mem_lw", 1'b1, bc, v(0,0,1,0,1,0,0,0,0,0,0,0,0));
        push("wb_lw", 1'b1, bc, v(0,0,0,0,0,0,0,0,1,1,0,0,0));
      end
      OP_STORE: begin
        push("exec_sw", 1'b1, bc, v(0,0,0,0,0,0,0,0,0,0,0,1,0));
        for (int i = 0; i < mw; i++) push("mem_sw_wait", 1'b0, bc, v(0,0,1,1,1,0,0,0,0,0,0,0,0));
        push("mem_sw", 1'b1, bc, v(0,0,1,1,1,0,0,0,0,0,0,0,0));
      end
      OP_BR: begin
        push("exec_br", 1'b1, bc, v(0,0,0,0,0,0,bc,(bc ? 2'd1 : 2'd0),0,0,0,0,1));
      end
      OP_JAL: begin
        push("exec_jal", 1'b1, bc, v(0,0,0,0,0,0,1,1,1,2,0,0,0));
      end
      OP_JALR: begin
        push("exec_jalr", 1'b1, bc, v(0,0,0,0,0,0,1,2,1,2,0,1,0));
      end
      default: begin
        legal = 1'b0;
        push("trap_ill", 1'b1, bc, v(1,1,0,0,0,0,0,0,0,0,0,0,0));
        push("trap_ill_hold", 1'b1, bc, v(1,1,0,0,0,0,0,0,0,0,0,0,0));
      end
    endcase
    run_queue();
    if (legal) exp_retired = exp_retired + 32'd1;
    check_val("retired", retired, exp_retired);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    do_instr(OP_R, 0, 0, 1'b0);
    do_instr(OP_I, 0, 0, 1'b0);
    do_instr(OP_LUI, 0, 0, 1'b0);
    do_instr(OP_AUIPC, 0, 0, 1'b0);
    check_val("retired_after_alu4", retired, 32'd4);

    do_instr(OP_LOAD, 0, 3, 1'b0);
    do_instr(OP_STORE, 0, 0, 1'b0);
    do_instr(OP_BR, 0, 0, 1'b1);
    do_instr(OP_BR, 0, 0, 1'b0);
    do_instr(OP_JAL, 0, 0, 1'b0);
    do_instr(OP_JALR, 0, 0, 1'b0);
    do_instr(OP_R, 3, 0, 1'b0);
    do_instr(OP_STORE, 1, 2, 1'b0);
    check_val("retired_mid", retired, 32'd12);

    do_instr(OP_FENCE, 0, 0, 1'b0);
    check_val("retired_after_ill", retired, 32'd12);

    do_reset();
    do_instr(OP_R, 0, 0, 1'b0);

    // Fetch that never completes: four wait cycles then a timeout trap.
    opcode = OP_R;
    for (int i = 0; i < 4; i++) push("fetch_to_wait", 1'b0, 1'b0, v(0,0,1,0,0,0,0,0,0,0,0,0,0));
    push("trap_to", 1'b0, 1'b0, v(2,1,0,0,0,0,0,0,0,0,0,0,0));
    push("trap_to_hold", 1'b1, 1'b0, v(2,1,0,0,0,0,0,0,0,0,0,0,0));
    run_queue();
    check_val("retired_after_to", retired, 32'd1);

    do_reset();
    // Load abandoned by reset while waiting in MEM.
    opcode = OP_LOAD;
    push_fetch(0, 1'b0);
    push("exec_lw", 1'b1, 1'b0, v(0,0,0,0,0,0,0,0,0,0,0,1,0));
    push("mem_lw_wait", 1'b0, 1'b0, v(0,0,1,0,1,0,0,0,0,0,0,0,0));
    run_queue();
    do_reset();
    do_instr(OP_I, 0, 0, 1'b0);
    check_val("retired_final", retired, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
